vga_sync_gen: RTL

//  640x480@60 Hz VGA timing generator. Consumes the 25 MHz pixel clock from the

---
 rtl/vga_sync_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator: free-running pixel/line counters with
// registered sync, visible-area and line/frame-start decode.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       CLK25MHZ,
  input  logic       CPU_RESETN,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_bad_timing
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must fit the 10-bit counters");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Boundaries can reach 1024, so they are compared at 11 bits.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       r_rst_sync;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_line_start;
  logic       r_frame_start;

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_video_on;
  logic       w_line_start;
  logic       w_frame_start;

  // Reset asserts asynchronously; release is retimed by one flop so the
  // counters leave (0,0) on the second edge after CPU_RESETN rises.
  always_ff @(posedge CLK25MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) r_rst_sync <= 1'b0;
    else             r_rst_sync <= 1'b1;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_x_next = r_x + 10'd1;
    w_y_next = r_y;
    if (r_x == H_LAST) begin
      w_x_next = '0;
      w_y_next = (r_y == V_LAST) ? '0 : r_y + 10'd1;
    end
  end

  // Decode the next state so the registered flags line up with the counters.
  always_comb begin
    w_hs_act      = ({1'b0, w_x_next} >= HS_START) && ({1'b0, w_x_next} < HS_END);
    w_vs_act      = ({1'b0, w_y_next} >= VS_START) && ({1'b0, w_y_next} < VS_END);
    w_video_on    = ({1'b0, w_x_next} < H_VIS) && ({1'b0, w_y_next} < V_VIS);
    w_line_start  = (w_x_next == '0);
    w_frame_start = (w_x_next == '0) && (w_y_next == '0);
  end

  always_ff @(posedge CLK25MHZ or negedge r_rst_sync) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!r_rst_sync) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video_on;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
